xnor_parity_ctrl: RTL
=====================

XNOR_PARITY_CTRL -- requirements
Module: xnor_parity_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of frame word counter.
REQ-002 SHALL have port: CK  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port: CD  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: REQ0, REQ1  input  1  requester 0/1 offers a word.
REQ-005 SHALL have ports: D0, D1  input  5  requester 0/1 data word.
REQ-006 SHALL have ports: LAST0, LAST1  input  1  offered word ends the frame.
REQ-007 SHALL have ports: GNT0, GNT1  output  1  combinational; word accepted this cycle when REQx & GNTx.
REQ-008 SHALL have port: Z  output  1  frame parity result (XNOR of all frame bits).
REQ-009 SHALL have port: ZV  output  1  one-cycle pulse; Z, ZID, CNT valid.
REQ-010 SHALL have port: ZID  output  1  requester index of the reported frame.
REQ-011 SHALL have port: CNT  output  CNT_W  words in the reported frame, LAST word included.
REQ-012 SHALL have port: BUSY  output  1  high while state is OWN.

Function
REQ-013 SHALL share one 5-input XNOR reduction between two requesters; word value w = NOT XNOR5(Dx) = XOR of the 5 bits.
REQ-014 SHALL implement states IDLE and OWN, with registers OWNER (1 bit) and PTR (priority pointer, 1 bit).
REQ-015 IDLE: SHALL grant REQ[PTR] if asserted, else REQ[~PTR]; at most one GNT high in any cycle.
REQ-016 IDLE, accepted word with LAST=0: SHALL go to OWN, OWNER = granted index.
REQ-017 IDLE, accepted word with LAST=1 (single-word frame): SHALL complete the frame, stay in IDLE, PTR = ~granted index.
REQ-018 OWN: SHALL assert only GNT[OWNER], gated by REQ[OWNER]; the other requester SHALL wait even if the owner idles mid-frame.
REQ-019 OWN, accepted word with LAST=1: SHALL go to IDLE, PTR = ~OWNER.
REQ-020 SHALL hold accumulator X (1 bit) and count C (CNT_W bits); first accepted word sets X=w, C=1; each later word sets X=X^w, C=C+1, saturating at 2^CNT_W-1.
REQ-021 On the cycle after the LAST word is accepted, SHALL drive ZV=1, Z=~(X^w), CNT=final C, ZID=granted index, with latency exactly 1 cycle.
REQ-022 SHALL hold Z, ZID and CNT stable between ZV pulses.
REQ-023 SHALL ignore LAST and D of non-granted requesters; a LAST of a non-granted requester SHALL have no effect.
REQ-024 Back-to-back frames: SHALL accept a new frame's first word in the cycle immediately following the LAST word, including from the other requester.

Reset
REQ-025 CD=1 at a CK edge SHALL set state=IDLE, PTR=0, OWNER=0, X=0, C=0, ZV=0, Z=0, ZID=0, CNT=0, BUSY=0.
REQ-026 While CD=1, GNT0 and GNT1 SHALL be 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no ZV SHALL be produced for it.

Structure
REQ-028 State encodings (IDLE=0, OWN=1) and requester count (2) SHALL reside in a shared include file, xnor_parity_defs.
REQ-029 SHALL instantiate one XNOR5 library cell as the shared word-reduction sub-module, its inputs muxed by the grant.
REQ-030 The remaining logic SHALL be a single flat module, 120-400 lines.

Verification
REQ-031 Reset, then REQ0=1, D0=5'b00001, LAST0=1 -> GNT0=1 same cycle; next cycle ZV=1, Z=0, CNT=1, ZID=0.
REQ-032 REQ0 frame of words 5'b00011, 5'b00100, then LAST 5'b11111 -> ZV=1, Z=1, CNT=3; GNT1 stays 0 throughout although REQ1=1.
REQ-033 REQ0=REQ1=1 continuously with single-word frames -> grants alternate 0,1,0,1; ZID alternates in step.
REQ-034 Owner REQ0 drops for 3 cycles mid-frame while REQ1=1 -> GNT1=0 and BUSY=1 for those cycles; frame completes correctly on resume.
REQ-035 Assert CD after 2 words of a frame -> no ZV; all outputs 0; next frame is granted to requester 0 first.
REQ-036 CNT_W=2 with a 5-word frame -> CNT=3 (saturated); Z correct over all 5 words.

Source files
------------

// File: rtl/xnor_parity_ctrl_pkg.sv
// ============================================================================
// Module : xnor_parity_defs (package)
// Brief  : Shared state encodings and requester count for xnor_parity_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package xnor_parity_defs;

    localparam int NUM_REQ = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/xnor_parity_ctrl_xnor5.sv
// ============================================================================
// Module : xnor_parity_ctrl_xnor5
// Brief  : Five-input XNOR reduction cell shared between the requesters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xnor_parity_ctrl_xnor5 (
    input  logic [4:0] a,
    output logic       y
);

    assign y = ~^a;

endmodule

`default_nettype wire

// File: rtl/xnor_parity_ctrl.sv
// ============================================================================
// Module : xnor_parity_ctrl
// Brief  : Two-requester frame arbiter reporting the XNOR parity of each frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xnor_parity_ctrl
    import xnor_parity_defs::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [4:0]       D0,
    input  logic [4:0]       D1,
    input  logic             LAST0,
    input  logic             LAST1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             Z,
    output logic             ZV,
    output logic             ZID,
    output logic [CNT_W-1:0] CNT,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t             r_state, w_state_nxt;
    logic               r_ptr, w_ptr_nxt;
    logic               r_owner, w_owner_nxt;
    logic               r_x, w_x_nxt;
    logic [CNT_W-1:0]   r_c, w_c_nxt;
    logic               r_zv, r_z, r_zid;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_sel;
    logic               w_acc;
    logic               w_last;
    logic [4:0]         w_data;
    logic               w_xnor;
    logic               w_word;
    logic               w_x_acc;
    logic [CNT_W-1:0]   w_c_acc;
    logic               w_done;

    assign w_req = {REQ1, REQ0};

    // Grant: pointer priority when idle, exclusive to the owner mid-frame.
    always_comb begin
        w_gnt = '0;
        if (!CD) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req[r_ptr])
                        w_gnt[r_ptr] = 1'b1;
                    else if (w_req[~r_ptr])
                        w_gnt[~r_ptr] = 1'b1;
                end
                ST_OWN:  w_gnt[r_owner] = w_req[r_owner];
                default: w_gnt = '0;
            endcase
        end
    end

    assign w_sel  = w_gnt[1];
    assign w_acc  = |w_gnt;
    assign w_data = w_sel ? D1 : D0;
    assign w_last = w_sel ? LAST1 : LAST0;

    xnor_parity_ctrl_xnor5 u_xnor5 (
        .a (w_data),
        .y (w_xnor)
    );

    assign w_word = ~w_xnor;

    // A frame always starts in IDLE, so IDLE marks the first word.
    assign w_x_acc = (r_state == ST_IDLE) ? w_word : (r_x ^ w_word);
    assign w_c_acc = (r_state == ST_IDLE) ? C_CNT_ONE :
                     (r_c == C_CNT_MAX)   ? r_c : r_c + C_CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_x_nxt     = r_x;
        w_c_nxt     = r_c;
        w_done      = 1'b0;
        if (w_acc) begin
            w_x_nxt = w_x_acc;
            w_c_nxt = w_c_acc;
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = ~w_sel;
                w_done      = 1'b1;
            end else begin
                w_state_nxt = ST_OWN;
                w_owner_nxt = w_sel;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_x     <= 1'b0;
            r_c     <= '0;
            r_zv    <= 1'b0;
            r_z     <= 1'b0;
            r_zid   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_x     <= w_x_nxt;
            r_c     <= w_c_nxt;
            r_zv    <= w_done;
            if (w_done) begin
                r_z   <= ~w_x_acc;
                r_zid <= w_sel;
                r_cnt <= w_c_acc;
            end
        end
    end

    assign GNT0 = w_gnt[0];
    assign GNT1 = w_gnt[1];
    assign Z    = r_z;
    assign ZV   = r_zv;
    assign ZID  = r_zid;
    assign CNT  = r_cnt;
    assign BUSY = (r_state == ST_OWN);

endmodule

`default_nettype wire
